// File: rtl/mqnic_rx_indir_tbl_fill.sv
// Fills one port's RSS indirection table slice over AXI-lite with a repeating
// run of queue indices base..base+count-1, one outstanding write at a time.
module mqnic_rx_indir_tbl_fill #(
  parameter int PORTS = 1,
  parameter int QUEUE_INDEX_WIDTH = 10,
  parameter int INDIR_TBL_ADDR_WIDTH = QUEUE_INDEX_WIDTH > 8 ? 8 : QUEUE_INDEX_WIDTH,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_ADDR_WIDTH = $clog2(PORTS)+INDIR_TBL_ADDR_WIDTH+2,
  parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH/8,
  parameter AXIL_BASE_ADDR = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [(PORTS > 1 ? $clog2(PORTS) : 1)-1:0] cmd_port,
  input  logic [QUEUE_INDEX_WIDTH-1:0]             cmd_base_queue,
  input  logic [QUEUE_INDEX_WIDTH:0]               cmd_queue_count,
  input  logic                                     cmd_valid,
  output logic                                     cmd_ready,
  input  logic                                     cmd_abort,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     aborted,
  output logic                                     error,
  output logic [AXIL_ADDR_WIDTH-1:0]               m_axil_awaddr,
  output logic [2:0]                               m_axil_awprot,
  output logic                                     m_axil_awvalid,
  input  logic                                     m_axil_awready,
  output logic [AXIL_DATA_WIDTH-1:0]               m_axil_wdata,
  output logic [AXIL_STRB_WIDTH-1:0]               m_axil_wstrb,
  output logic                                     m_axil_wvalid,
  input  logic                                     m_axil_wready,
  input  logic [1:0]                               m_axil_bresp,
  input  logic                                     m_axil_bvalid,
  output logic                                     m_axil_bready
);
  localparam int PW = PORTS > 1 ? $clog2(PORTS) : 1;
  localparam int QW = QUEUE_INDEX_WIDTH;
  localparam int IA = INDIR_TBL_ADDR_WIDTH;
  localparam int AW = AXIL_ADDR_WIDTH;
  localparam int DW = AXIL_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, WRITE, RESP, DONE} state_t;
  state_t state, state_next;

  logic [PW-1:0] port_r;
  logic [QW-1:0] base_r;
  logic [QW:0]   count_r, q, q_inc, q_next;
  logic [IA-1:0] idx, idx_inc;
  logic          abort_pend, abort_now, last_entry;
  logic          aw_vld, w_vld, err_r, abrt_r;
  logic [AW-1:0] aw_addr;
  logic [DW-1:0] w_data;

  // Address arithmetic is modulo 2^AW; out-of-range ports are passed through.
  function automatic logic [AW-1:0] entry_addr(input logic [PW-1:0] p, input logic [IA-1:0] e);
    return AW'(AXIL_BASE_ADDR) + (AW'(p) << (IA+2)) + (AW'(e) << 2);
  endfunction

  function automatic logic [DW-1:0] entry_data(input logic [QW-1:0] b, input logic [QW-1:0] o);
    logic [DW-1:0] d;
    d = '0;
    d[QW-1:0] = b + o;
    return d;
  endfunction

  assign idx_inc    = idx + 1'b1;
  assign q_inc      = q + 1'b1;
  assign q_next     = (q_inc == count_r) ? '0 : q_inc;
  assign last_entry = (idx == '1);
  assign abort_now  = abort_pend | cmd_abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (cmd_valid) state_next = WRITE;
      // a channel counts as accepted once its valid has dropped or ready is seen now
      WRITE: if ((!aw_vld || m_axil_awready) && (!w_vld || m_axil_wready)) state_next = RESP;
      RESP:  if (m_axil_bvalid) state_next = (last_entry || abort_now) ? DONE : WRITE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_r <= '0; base_r <= '0; count_r <= '0; q <= '0; idx <= '0;
      abort_pend <= 1'b0; aw_vld <= 1'b0; w_vld <= 1'b0;
      err_r <= 1'b0; abrt_r <= 1'b0; aw_addr <= '0; w_data <= '0;
    end else begin
      if (aw_vld && m_axil_awready) aw_vld <= 1'b0;
      if (w_vld && m_axil_wready)   w_vld  <= 1'b0;
      if (state != IDLE && cmd_abort) abort_pend <= 1'b1;
      case (state)
        IDLE: if (cmd_valid) begin
          port_r     <= cmd_port;
          base_r     <= cmd_base_queue;
          count_r    <= (cmd_queue_count == '0) ? (QW+1)'(1) : cmd_queue_count;
          q          <= '0;
          idx        <= '0;
          abort_pend <= 1'b0;
          err_r      <= 1'b0;
          abrt_r     <= 1'b0;
          aw_vld     <= 1'b1;
          w_vld      <= 1'b1;
          aw_addr    <= entry_addr(cmd_port, '0);
          w_data     <= entry_data(cmd_base_queue, '0);
        end
        RESP: if (m_axil_bvalid) begin
          err_r <= err_r | (m_axil_bresp != 2'b00);
          if (last_entry || abort_now) begin
            abrt_r <= abort_now;
          end else begin
            idx     <= idx_inc;
            q       <= q_next;
            aw_vld  <= 1'b1;
            w_vld   <= 1'b1;
            aw_addr <= entry_addr(port_r, idx_inc);
            w_data  <= entry_data(base_r, q_next[QW-1:0]);
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready      = (state == IDLE);
  assign busy           = (state == WRITE) || (state == RESP);
  assign done           = (state == DONE);
  assign aborted        = abrt_r;
  assign error          = err_r;
  assign m_axil_awaddr  = aw_addr;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = aw_vld;
  assign m_axil_wdata   = w_data;
  assign m_axil_wstrb   = '1;
  assign m_axil_wvalid  = w_vld;
  assign m_axil_bready  = (state == RESP);
endmodule
